// File: rtl/controle_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module      : controle_multiciclo_if
// Description : Bundle between the multicycle controller and its datapath:
//               IR fields and memory handshake in, control lines out.
// Revision    : 1.0 - initial release
// ============================================================================
interface controle_multiciclo_if #(
    parameter int CONT_W = 16
);
    logic [2:0]        opcode;
    logic [3:0]        funct;
    logic              mem_pronto;

    logic              iord;
    logic              mem_leitura;
    logic              mem_escrita;
    logic              ir_escrita;
    logic              pc_escrita;
    logic              pc_escrita_cond;
    logic [1:0]        pc_fonte;
    logic              ula_src_a;
    logic [1:0]        ula_src_b;
    logic [1:0]        ula_op;
    logic              sign_zero;
    logic [1:0]        reg_dest;
    logic [1:0]        mem_to_reg;
    logic              reg_escrita;
    logic              instrucao_fim;
    logic [3:0]        estado;
    logic [CONT_W-1:0] contagem;

    modport master (
        input  opcode, funct, mem_pronto,
        output iord, mem_leitura, mem_escrita, ir_escrita, pc_escrita,
               pc_escrita_cond, pc_fonte, ula_src_a, ula_src_b, ula_op,
               sign_zero, reg_dest, mem_to_reg, reg_escrita, instrucao_fim,
               estado, contagem
    );

    modport slave (
        output opcode, funct, mem_pronto,
        input  iord, mem_leitura, mem_escrita, ir_escrita, pc_escrita,
               pc_escrita_cond, pc_fonte, ula_src_a, ula_src_b, ula_op,
               sign_zero, reg_dest, mem_to_reg, reg_escrita, instrucao_fim,
               estado, contagem
    );
endinterface
`default_nettype wire

// File: rtl/controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : controle_multiciclo
// Description : Moore control FSM for the multicycle 16-bit MIPS datapath
//               with a shared memory port and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_multiciclo #(
    parameter logic [2:0] OP_R     = 3'b000,
    parameter logic [2:0] OP_LW    = 3'b001,
    parameter logic [2:0] OP_SW    = 3'b010,
    parameter logic [2:0] OP_BEQ   = 3'b011,
    parameter logic [2:0] OP_ADDI  = 3'b100,
    parameter logic [2:0] OP_SLTI  = 3'b101,
    parameter logic [2:0] OP_J     = 3'b110,
    parameter logic [2:0] OP_JAL   = 3'b111,
    parameter logic [3:0] FUNCT_JR = 4'b1000,
    parameter int         CONT_W   = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    controle_multiciclo_if.master bus
);

    localparam logic [3:0] c_busca        = 4'd0;
    localparam logic [3:0] c_decod        = 4'd1;
    localparam logic [3:0] c_exec_r       = 4'd2;
    localparam logic [3:0] c_escr_r       = 4'd3;
    localparam logic [3:0] c_calc_end     = 4'd4;
    localparam logic [3:0] c_le_mem       = 4'd5;
    localparam logic [3:0] c_escr_mem_reg = 4'd6;
    localparam logic [3:0] c_escr_mem     = 4'd7;
    localparam logic [3:0] c_exec_i       = 4'd8;
    localparam logic [3:0] c_escr_i       = 4'd9;
    localparam logic [3:0] c_branch       = 4'd10;
    localparam logic [3:0] c_jump         = 4'd11;
    localparam logic [3:0] c_jal          = 4'd12;
    localparam logic [3:0] c_jr           = 4'd13;

    logic [3:0]        r_estado;
    logic [3:0]        w_prox;
    logic [CONT_W-1:0] r_contagem;

    logic       w_iord;
    logic       w_mem_leitura;
    logic       w_mem_escrita;
    logic       w_ir_escrita;
    logic       w_pc_escrita;
    logic       w_pc_escrita_cond;
    logic [1:0] w_pc_fonte;
    logic       w_ula_src_a;
    logic [1:0] w_ula_src_b;
    logic [1:0] w_ula_op;
    logic       w_sign_zero;
    logic [1:0] w_reg_dest;
    logic [1:0] w_mem_to_reg;
    logic       w_reg_escrita;
    logic       w_fim;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= c_busca;
        end else begin
            r_estado <= w_prox;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_prox = c_busca;
        case (r_estado)
            c_busca:        w_prox = bus.mem_pronto ? c_decod : c_busca;
            c_decod: begin
                case (bus.opcode)
                    OP_R:            w_prox = (bus.funct == FUNCT_JR) ? c_jr : c_exec_r;
                    OP_LW, OP_SW:    w_prox = c_calc_end;
                    OP_BEQ:          w_prox = c_branch;
                    OP_ADDI, OP_SLTI: w_prox = c_exec_i;
                    OP_J:            w_prox = c_jump;
                    OP_JAL:          w_prox = c_jal;
                    default:         w_prox = c_busca;
                endcase
            end
            c_exec_r:       w_prox = c_escr_r;
            c_calc_end:     w_prox = (bus.opcode == OP_LW) ? c_le_mem : c_escr_mem;
            c_le_mem:       w_prox = bus.mem_pronto ? c_escr_mem_reg : c_le_mem;
            c_escr_mem:     w_prox = bus.mem_pronto ? c_busca : c_escr_mem;
            c_exec_i:       w_prox = c_escr_i;
            default:        w_prox = c_busca;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic; reset forces every line low without waiting for a clock
    // ------------------------------------------------------------------
    always_comb begin
        w_iord            = 1'b0;
        w_mem_leitura     = 1'b0;
        w_mem_escrita     = 1'b0;
        w_ir_escrita      = 1'b0;
        w_pc_escrita      = 1'b0;
        w_pc_escrita_cond = 1'b0;
        w_pc_fonte        = 2'b00;
        w_ula_src_a       = 1'b0;
        w_ula_src_b       = 2'b00;
        w_ula_op          = 2'b00;
        w_sign_zero       = 1'b0;
        w_reg_dest        = 2'b00;
        w_mem_to_reg      = 2'b00;
        w_reg_escrita     = 1'b0;
        w_fim             = 1'b0;
        if (!reset) begin
            case (r_estado)
                c_busca: begin
                    w_mem_leitura = 1'b1;
                    if (bus.mem_pronto) begin
                        w_ir_escrita = 1'b1;
                        w_pc_escrita = 1'b1;
                        w_ula_src_b  = 2'b01;
                    end
                end
                c_decod: begin
                    w_ula_src_b = 2'b11;
                    w_sign_zero = 1'b1;
                end
                c_exec_r: begin
                    w_ula_src_a = 1'b1;
                    w_ula_op    = 2'b10;
                end
                c_escr_r: begin
                    w_reg_escrita = 1'b1;
                    w_fim         = 1'b1;
                end
                c_calc_end: begin
                    w_ula_src_a = 1'b1;
                    w_ula_src_b = 2'b10;
                    w_sign_zero = 1'b1;
                end
                c_le_mem: begin
                    w_iord        = 1'b1;
                    w_mem_leitura = 1'b1;
                end
                c_escr_mem_reg: begin
                    w_reg_dest    = 2'b01;
                    w_mem_to_reg  = 2'b01;
                    w_reg_escrita = 1'b1;
                    w_fim         = 1'b1;
                end
                c_escr_mem: begin
                    w_iord        = 1'b1;
                    w_mem_escrita = 1'b1;
                    w_fim         = bus.mem_pronto;
                end
                c_exec_i: begin
                    w_ula_src_a = 1'b1;
                    w_ula_src_b = 2'b10;
                    // SLTI compares against an unsigned immediate
                    if (bus.opcode == OP_SLTI) begin
                        w_ula_op    = 2'b11;
                        w_sign_zero = 1'b0;
                    end else begin
                        w_ula_op    = 2'b00;
                        w_sign_zero = 1'b1;
                    end
                end
                c_escr_i: begin
                    w_reg_dest    = 2'b01;
                    w_reg_escrita = 1'b1;
                    w_fim         = 1'b1;
                end
                c_branch: begin
                    w_ula_src_a       = 1'b1;
                    w_ula_op          = 2'b01;
                    w_pc_escrita_cond = 1'b1;
                    w_pc_fonte        = 2'b01;
                    w_fim             = 1'b1;
                end
                c_jump: begin
                    w_pc_escrita = 1'b1;
                    w_pc_fonte   = 2'b10;
                    w_fim        = 1'b1;
                end
                c_jal: begin
                    // PC already holds the return address (PC+2) from fetch
                    w_reg_dest    = 2'b10;
                    w_mem_to_reg  = 2'b10;
                    w_reg_escrita = 1'b1;
                    w_pc_escrita  = 1'b1;
                    w_pc_fonte    = 2'b10;
                    w_fim         = 1'b1;
                end
                c_jr: begin
                    w_pc_escrita = 1'b1;
                    w_pc_fonte   = 2'b11;
                    w_fim        = 1'b1;
                end
                default: begin
                    w_fim = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter, wraps naturally
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (w_fim) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign bus.iord            = w_iord;
    assign bus.mem_leitura     = w_mem_leitura;
    assign bus.mem_escrita     = w_mem_escrita;
    assign bus.ir_escrita      = w_ir_escrita;
    assign bus.pc_escrita      = w_pc_escrita;
    assign bus.pc_escrita_cond = w_pc_escrita_cond;
    assign bus.pc_fonte        = w_pc_fonte;
    assign bus.ula_src_a       = w_ula_src_a;
    assign bus.ula_src_b       = w_ula_src_b;
    assign bus.ula_op          = w_ula_op;
    assign bus.sign_zero       = w_sign_zero;
    assign bus.reg_dest        = w_reg_dest;
    assign bus.mem_to_reg      = w_mem_to_reg;
    assign bus.reg_escrita     = w_reg_escrita;
    assign bus.instrucao_fim   = w_fim;
    assign bus.estado          = r_estado;
    assign bus.contagem        = r_contagem;

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_multiciclo
// Description : Random instruction streams against a per-instruction state
//               path model; a 3-bit counter instance exercises wraparound.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_multiciclo;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SLTI = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_JAL  = 3'b111;
    localparam logic [3:0] FN_JR   = 4'b1000;

    typedef struct packed {
        logic       iord;
        logic       mem_leitura;
        logic       mem_escrita;
        logic       ir_escrita;
        logic       pc_escrita;
        logic       pc_escrita_cond;
        logic [1:0] pc_fonte;
        logic       ula_src_a;
        logic [1:0] ula_src_b;
        logic [1:0] ula_op;
        logic       sign_zero;
        logic [1:0] reg_dest;
        logic [1:0] mem_to_reg;
        logic       reg_escrita;
        logic       instrucao_fim;
    } ctl_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    controle_multiciclo_if bus ();
    controle_multiciclo_if #(.CONT_W(3)) bus3 ();

    assign bus3.opcode     = bus.opcode;
    assign bus3.funct      = bus.funct;
    assign bus3.mem_pronto = bus.mem_pronto;

    controle_multiciclo dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    controle_multiciclo #(.CONT_W(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    ctl_t obs;
    assign obs = {bus.iord, bus.mem_leitura, bus.mem_escrita, bus.ir_escrita,
                  bus.pc_escrita, bus.pc_escrita_cond, bus.pc_fonte,
                  bus.ula_src_a, bus.ula_src_b, bus.ula_op, bus.sign_zero,
                  bus.reg_dest, bus.mem_to_reg, bus.reg_escrita,
                  bus.instrucao_fim};

    int n_checks  = 0;
    int n_errors  = 0;
    int n_retired = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Control lines each state must show, straight from the state table
    function automatic ctl_t exp_ctl(input int st, input logic pr, input logic [2:0] op);
        ctl_t c;
        c = '0;
        case (st)
            0: begin
                c.mem_leitura = 1'b1;
                if (pr) begin
                    c.ir_escrita = 1'b1;
                    c.pc_escrita = 1'b1;
                    c.ula_src_b  = 2'b01;
                end
            end
            1: begin c.ula_src_b = 2'b11; c.sign_zero = 1'b1; end
            2: begin c.ula_src_a = 1'b1; c.ula_op = 2'b10; end
            3: begin c.reg_escrita = 1'b1; c.instrucao_fim = 1'b1; end
            4: begin c.ula_src_a = 1'b1; c.ula_src_b = 2'b10; c.sign_zero = 1'b1; end
            5: begin c.iord = 1'b1; c.mem_leitura = 1'b1; end
            6: begin
                c.reg_dest = 2'b01; c.mem_to_reg = 2'b01;
                c.reg_escrita = 1'b1; c.instrucao_fim = 1'b1;
            end
            7: begin c.iord = 1'b1; c.mem_escrita = 1'b1; c.instrucao_fim = pr; end
            8: begin
                c.ula_src_a = 1'b1; c.ula_src_b = 2'b10;
                c.ula_op    = (op == OP_SLTI) ? 2'b11 : 2'b00;
                c.sign_zero = (op == OP_SLTI) ? 1'b0 : 1'b1;
            end
            9: begin c.reg_dest = 2'b01; c.reg_escrita = 1'b1; c.instrucao_fim = 1'b1; end
            10: begin
                c.ula_src_a = 1'b1; c.ula_op = 2'b01; c.pc_escrita_cond = 1'b1;
                c.pc_fonte = 2'b01; c.instrucao_fim = 1'b1;
            end
            11: begin c.pc_escrita = 1'b1; c.pc_fonte = 2'b10; c.instrucao_fim = 1'b1; end
            12: begin
                c.reg_dest = 2'b10; c.mem_to_reg = 2'b10; c.reg_escrita = 1'b1;
                c.pc_escrita = 1'b1; c.pc_fonte = 2'b10; c.instrucao_fim = 1'b1;
            end
            13: begin c.pc_escrita = 1'b1; c.pc_fonte = 2'b11; c.instrucao_fim = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // One clock: drive inputs, sample mid-cycle, advance past the rising edge
    task automatic step(input int st, input logic pr, input logic [2:0] op, input logic [3:0] fn);
        if (st == 0 && !pr) begin
            bus.opcode = 3'($urandom);
            bus.funct  = 4'($urandom);
        end else begin
            bus.opcode = op;
            bus.funct  = fn;
        end
        bus.mem_pronto = pr;
        @(negedge clock);
        chk("estado", 32'(bus.estado), 32'(st));
        chk("ctl", 32'(obs), 32'(exp_ctl(st, pr, op)));
        chk("contagem", 32'(bus.contagem), 32'(n_retired % 65536));
        chk("contagem_w3", 32'(bus3.contagem), 32'(n_retired % 8));
        @(posedge clock);
        #1;
    endtask

    // Builds the visited-state path of one instruction and walks it
    task automatic run_instr(input logic [2:0] op, input logic [3:0] fn, input int wf, input int wm);
        int  q_st[$];
        bit  q_pr[$];
        for (int i = 0; i < wf; i++) begin q_st.push_back(0); q_pr.push_back(1'b0); end
        q_st.push_back(0); q_pr.push_back(1'b1);
        q_st.push_back(1); q_pr.push_back(1'($urandom));
        case (op)
            OP_R: begin
                if (fn == FN_JR) begin q_st.push_back(13); q_pr.push_back(1'($urandom)); end
                else begin
                    q_st.push_back(2); q_pr.push_back(1'($urandom));
                    q_st.push_back(3); q_pr.push_back(1'($urandom));
                end
            end
            OP_LW: begin
                q_st.push_back(4); q_pr.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin q_st.push_back(5); q_pr.push_back(1'b0); end
                q_st.push_back(5); q_pr.push_back(1'b1);
                q_st.push_back(6); q_pr.push_back(1'($urandom));
            end
            OP_SW: begin
                q_st.push_back(4); q_pr.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin q_st.push_back(7); q_pr.push_back(1'b0); end
                q_st.push_back(7); q_pr.push_back(1'b1);
            end
            OP_BEQ: begin q_st.push_back(10); q_pr.push_back(1'($urandom)); end
            OP_ADDI, OP_SLTI: begin
                q_st.push_back(8); q_pr.push_back(1'($urandom));
                q_st.push_back(9); q_pr.push_back(1'($urandom));
            end
            OP_J: begin q_st.push_back(11); q_pr.push_back(1'($urandom)); end
            default: begin q_st.push_back(12); q_pr.push_back(1'($urandom)); end
        endcase
        foreach (q_st[i]) step(q_st[i], q_pr[i], op, fn);
        n_retired++;
    endtask

    initial begin
        bus.opcode     = 3'b000;
        bus.funct      = 4'b0000;
        bus.mem_pronto = 1'b1;

        // Held in reset: everything low even though BUSCA would read memory
        repeat (2) begin
            @(negedge clock);
            chk("rst_estado", 32'(bus.estado), 32'd0);
            chk("rst_ctl", 32'(obs), 32'd0);
            chk("rst_contagem", 32'(bus.contagem), 32'd0);
        end
        @(posedge clock);
        #1 reset = 1'b0;

        run_instr(OP_R,    4'b0000, 0, 0);
        run_instr(OP_LW,   4'b0000, 0, 3);
        run_instr(OP_SLTI, 4'b0101, 1, 0);
        run_instr(OP_ADDI, 4'b1000, 0, 0);
        run_instr(OP_JAL,  4'b0000, 0, 0);
        run_instr(OP_R,    FN_JR,   0, 0);
        run_instr(OP_SW,   4'b0000, 2, 2);

        // Abort a store while it is waiting on memory
        step(0, 1'b1, OP_SW, 4'b0000);
        step(1, 1'b0, OP_SW, 4'b0000);
        step(4, 1'b1, OP_SW, 4'b0000);
        bus.mem_pronto = 1'b0;
        @(negedge clock);
        chk("abort_pre_escrita", 32'(bus.mem_escrita), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_escrita", 32'(bus.mem_escrita), 32'd0);
        chk("abort_estado", 32'(bus.estado), 32'd0);
        chk("abort_contagem", 32'(bus.contagem), 32'd0);
        chk("abort_ctl", 32'(obs), 32'd0);
        n_retired = 0;
        @(posedge clock);
        #1 reset = 1'b0;

        for (int k = 0; k < 400; k++) begin
            logic [2:0] op;
            logic [3:0] fn;
            int wf, wm;
            op = 3'($urandom);
            fn = ($urandom_range(0, 3) == 0) ? FN_JR : 4'($urandom);
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_instr(op, fn, wf, wm);
        end

        step(0, 1'b0, OP_R, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Moore FSM that sequences a multicycle variant of the 16-bit MIPS datapath.
- Instruction and data accesses share a single memory port, guarded by a ready handshake.
- Drives the select and enable lines for the shared memory, the IR, the PC, the register bank and the ALU.
- Decodes the 3-bit opcode and 4-bit funct held in the IR.
- Reports instruction completion and keeps a retired-instruction count.

Parameters:
- OP_R, 3'b000, R-type opcode
- OP_LW, 3'b001, load word
- OP_SW, 3'b010, store word
- OP_BEQ, 3'b011, branch if equal
- OP_ADDI, 3'b100, add immediate (sign-extended)
- OP_SLTI, 3'b101, set-less-than immediate (zero-extended)
- OP_J, 3'b110, jump
- OP_JAL, 3'b111, jump and link to $7
- FUNCT_JR, 4'b1000, funct code of jr within R-type

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  3  IR[15:13]
- funct  in  4  IR[3:0]
- mem_pronto  in  1  memory access completes this cycle
- iord  out  1  memory address source: 0=PC, 1=ALUOut
- mem_leitura  out  1  memory read request
- mem_escrita  out  1  memory write request
- ir_escrita  out  1  load IR
- pc_escrita  out  1  unconditional PC write
- pc_escrita_cond  out  1  PC write gated by ALU zero
- pc_fonte  out  2  00=ALU, 01=ALUOut, 10=IR[12:0] jump target, 11=rs value
- ula_src_a  out  1  0=PC, 1=reg A
- ula_src_b  out  2  00=reg B, 01=constant 2, 10=imm ext, 11=branch offset
- ula_op  out  2  00=add, 01=sub, 10=funct, 11=slt
- sign_zero  out  1  1=sign-extend imm, 0=zero-extend
- reg_dest  out  2  00=rd IR[6:4], 01=rt IR[9:7], 10=$7
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- reg_escrita  out  1  register bank write
- instrucao_fim  out  1  1-cycle pulse in the last state of each instruction
- estado  out  4  current state code (debug)
- contagem  out  16  retired-instruction count

Behaviour:
- Reset:
  - Asynchronous; state goes to BUSCA(0) and contagem to 0.
  - While reset=1, every enable/request output is 0 and every select is 0.
- State codes and outputs (outputs not listed are 0 in that state):
  - BUSCA(0): iord=0, mem_leitura=1. When mem_pronto=1: ir_escrita=1, pc_escrita=1, ula_src_a=0, ula_src_b=01, pc_fonte=00, then go to DECOD. Otherwise stay, with no write enables asserted.
  - DECOD(1): ula_src_a=0, ula_src_b=11, ula_op=00, sign_zero=1. Next state by opcode:
    - R with funct=FUNCT_JR -> JR(13)
    - R otherwise -> EXEC_R(2)
    - LW or SW -> CALC_END(4)
    - BEQ -> BRANCH(10)
    - ADDI or SLTI -> EXEC_I(8)
    - J -> JUMP(11)
    - JAL -> JAL(12)
  - EXEC_R(2): ula_src_a=1, ula_src_b=00, ula_op=10 -> ESCR_R.
  - ESCR_R(3): reg_dest=00, mem_to_reg=00, reg_escrita=1, fim -> BUSCA.
  - CALC_END(4): ula_src_a=1, ula_src_b=10, sign_zero=1, ula_op=00 -> LE_MEM for LW, ESCR_MEM for SW.
  - LE_MEM(5): iord=1, mem_leitura=1; hold until mem_pronto=1 -> ESCR_MEM_REG.
  - ESCR_MEM_REG(6): reg_dest=01, mem_to_reg=01, reg_escrita=1, fim -> BUSCA.
  - ESCR_MEM(7): iord=1, mem_escrita=1; hold until mem_pronto=1, with fim in the completing cycle -> BUSCA.
  - EXEC_I(8): ula_src_a=1, ula_src_b=10.
    - ADDI: ula_op=00, sign_zero=1.
    - SLTI: ula_op=11, sign_zero=0.
    - -> ESCR_I.
  - ESCR_I(9): reg_dest=01, mem_to_reg=00, reg_escrita=1, fim -> BUSCA.
  - BRANCH(10): ula_src_a=1, ula_src_b=00, ula_op=01, pc_escrita_cond=1, pc_fonte=01, fim -> BUSCA.
  - JUMP(11): pc_escrita=1, pc_fonte=10, fim -> BUSCA.
  - JAL(12): reg_dest=10, mem_to_reg=10, reg_escrita=1, pc_escrita=1, pc_fonte=10, fim -> BUSCA. The register write captures PC, which is already PC+2 from BUSCA.
  - JR(13): pc_escrita=1, pc_fonte=11, fim -> BUSCA.
  - Codes 14 and 15: all outputs 0, next state BUSCA, no fim.
- Memory wait states (BUSCA, LE_MEM, ESCR_MEM): all outputs are held constant while mem_pronto=0, with no limit on wait length. mem_pronto is ignored in all other states.
- contagem:
  - Increments by 1 on each clock edge where instrucao_fim=1.
  - Wraps from 16'hFFFF to 0.
- Latency in cycles, counting zero memory wait:
  - R-type, ADDI, SLTI, LW: 4, except LW: 5
  - SW: 4
  - BEQ, J, JAL, JR: 3
- Reset asserted mid-instruction aborts it immediately. No partial write enable is asserted after reset rises.
- opcode and funct are read only in DECOD, CALC_END and EXEC_I, and must come from the IR.

Test Plan:
- Reset, then release with opcode=000, funct=0000, mem_pronto=1 -> estado sequence 0,1,2,3,0; reg_escrita=1 only in state 3; contagem=1.
- LW with mem_pronto low for 3 cycles in LE_MEM -> state 5 held 4 cycles with iord=1 and mem_leitura=1 throughout; then state 6 with mem_to_reg=01, reg_dest=01; total 8 cycles.
- SLTI, then ADDI -> EXEC_I drives sign_zero=0, ula_op=11 for SLTI, then sign_zero=1, ula_op=00 for ADDI; contagem=2.
- JAL, then R-type with funct=1000 -> state 12 with reg_dest=10, mem_to_reg=10, pc_fonte=10; then state 13 with pc_fonte=11, reg_escrita=0.
- Reset pulsed during ESCR_MEM with mem_escrita=1 -> mem_escrita falls asynchronously, estado=0, contagem=0.
- Preload contagem path with 65535 retired instructions -> next fim wraps contagem to 0.
